// File: rtl/ddr3_amm_arbiter.sv
// ddr3_amm_arbiter: two-client arbiter in front of the DDR3 EMIF Avalon-MM user
// port (ctrl_amm_0), clocked by emif_usr_clk.
// Round-robin command selection; a write burst holds the grant until its last
// beat. Accepted reads are tagged so returned beats reach the client that issued them.
// Build option: define DDR_ARB_FIXED_PRIO_EN to make client 0 always win in IDLE.
//
// Handshake: a command or write beat transfers in any cycle where amm_ready is
// high and amm_read or amm_write is high. The accepting client sees sN_ready in
// that same cycle, and may change its fields afterwards. Read beats have no
// backpressure: each amm_readdatavalid beat is forwarded to its owner in the same cycle.

module ddr3_amm_arbiter #(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 320,
    parameter int BE_W      = 40,
    parameter int BURST_W   = 7,
    parameter int TAG_DEPTH = 16
) (
    input  logic               emif_usr_clk,
    input  logic               emif_usr_rst,
    // client 0
    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [ADDR_W-1:0]  s0_address,
    input  logic [DATA_W-1:0]  s0_writedata,
    input  logic [BE_W-1:0]    s0_byteenable,
    input  logic [BURST_W-1:0] s0_burstcount,
    output logic               s0_ready,
    output logic [DATA_W-1:0]  s0_readdata,
    output logic               s0_readdatavalid,
    // client 1
    input  logic               s1_read,
    input  logic               s1_write,
    input  logic [ADDR_W-1:0]  s1_address,
    input  logic [DATA_W-1:0]  s1_writedata,
    input  logic [BE_W-1:0]    s1_byteenable,
    input  logic [BURST_W-1:0] s1_burstcount,
    output logic               s1_ready,
    output logic [DATA_W-1:0]  s1_readdata,
    output logic               s1_readdatavalid,
    // EMIF controller
    input  logic               amm_ready,
    output logic               amm_read,
    output logic               amm_write,
    output logic [ADDR_W-1:0]  amm_address,
    output logic [DATA_W-1:0]  amm_writedata,
    output logic [BE_W-1:0]    amm_byteenable,
    output logic [BURST_W-1:0] amm_burstcount,
    input  logic [DATA_W-1:0]  amm_readdata,
    input  logic               amm_readdatavalid,
    // debug: current arbiter state (0 = IDLE, 1 = WR_BURST)
    output logic               dbg_state
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int TAG_W = BURST_W + 1;
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]     CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]     CNT_FULL  = (PTR_W + 1)'(TAG_DEPTH);

    typedef enum logic {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic               grant, grant_nxt;
    logic [BURST_W-1:0] wr_left, wr_left_nxt;
    logic [BURST_W-1:0] rd_left;

    // tag FIFO: {owner, beat count} per outstanding read command
    logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   tag_wptr, tag_rptr;
    logic [PTR_W:0]     tag_cnt;
    logic               tag_full, tag_empty, tag_push, tag_pop;
    logic               head_owner;
    logic [BURST_W-1:0] head_cnt, beats_left;
    logic               rd_beat;

    logic               elig0, elig1, fifo_ok;
    logic               sel, sel_valid, sel_read, sel_write, accept;
    logic [BURST_W-1:0] sel_burst, sel_burst_eff;

`ifndef DDR_ARB_FIXED_PRIO_EN
    logic               rr_ptr;
`endif

    assign dbg_state = state;

    // ---------------- read return ----------------
    assign tag_full   = (tag_cnt == CNT_FULL);
    assign tag_empty  = (tag_cnt == '0);
    assign head_owner = tag_mem[tag_rptr][TAG_W-1];
    assign head_cnt   = tag_mem[tag_rptr][BURST_W-1:0];
    // a beat with nothing outstanding is a protocol error and is dropped
    assign rd_beat    = amm_readdatavalid && !tag_empty && !emif_usr_rst;
    // rd_left == 0 means the head burst has not returned any beat yet
    assign beats_left = (rd_left == '0) ? head_cnt : rd_left;
    assign tag_pop    = rd_beat && (beats_left == BURST_ONE);

    assign s0_readdatavalid = rd_beat && !head_owner;
    assign s1_readdatavalid = rd_beat && head_owner;
    assign s0_readdata      = amm_readdata;
    assign s1_readdata      = amm_readdata;

    // ---------------- command selection ----------------
    // a full FIFO still takes a read in the cycle the head burst retires
    assign fifo_ok = !tag_full || tag_pop;
    assign elig0   = s0_write || (s0_read && fifo_ok);
    assign elig1   = s1_write || (s1_read && fifo_ok);

    // pick the client driving the EMIF this cycle
    always_comb begin
        sel       = 1'b0;
        sel_valid = 1'b0;
        case (state)
            IDLE: begin
                sel_valid = elig0 || elig1;
`ifdef DDR_ARB_FIXED_PRIO_EN
                sel       = elig1 && !elig0;
`else
                sel       = elig1 && (!elig0 || rr_ptr);
`endif
            end
            WR_BURST: begin
                // only write beats of the locked client; reads wait
                sel       = grant;
                sel_valid = grant ? s1_write : s0_write;
            end
            default: ;
        endcase
    end

    assign sel_read      = sel ? s1_read : s0_read;
    assign sel_write     = sel ? s1_write : s0_write;
    assign sel_burst     = sel ? s1_burstcount : s0_burstcount;
    assign sel_burst_eff = (sel_burst == '0) ? BURST_ONE : sel_burst;

    // write wins when a client raises both strobes
    assign amm_write      = !emif_usr_rst && sel_valid && sel_write;
    assign amm_read       = !emif_usr_rst && sel_valid && !sel_write && sel_read;
    assign amm_address    = sel ? s1_address : s0_address;
    assign amm_writedata  = sel ? s1_writedata : s0_writedata;
    assign amm_byteenable = sel ? s1_byteenable : s0_byteenable;
    assign amm_burstcount = sel_burst;

    assign accept   = amm_ready && (amm_read || amm_write);
    assign s0_ready = accept && !sel;
    assign s1_ready = accept && sel;
    assign tag_push = accept && amm_read;

    // next-state logic: enter WR_BURST on a multi-beat write, leave on its last beat
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        wr_left_nxt = wr_left;
        case (state)
            IDLE: begin
                if (accept && amm_write && (sel_burst_eff != BURST_ONE)) begin
                    state_nxt   = WR_BURST;
                    grant_nxt   = sel;
                    wr_left_nxt = sel_burst_eff - BURST_ONE;
                end
            end
            WR_BURST: begin
                if (accept) begin
                    if (wr_left == BURST_ONE) begin
                        state_nxt   = IDLE;
                        wr_left_nxt = '0;
                    end else begin
                        wr_left_nxt = wr_left - BURST_ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, grant lock and remaining write beats
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            state   <= IDLE;
            grant   <= 1'b0;
            wr_left <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            wr_left <= wr_left_nxt;
        end
    end

`ifndef DDR_ARB_FIXED_PRIO_EN
    // round-robin pointer prefers the client that was not served last
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= !sel;
        end
    end
`endif

    // tag FIFO pointers, occupancy and beats left in the head burst
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            tag_wptr <= '0;
            tag_rptr <= '0;
            tag_cnt  <= '0;
            rd_left  <= '0;
        end else begin
            if (tag_push) tag_wptr <= tag_wptr + PTR_ONE;
            if (tag_pop)  tag_rptr <= tag_rptr + PTR_ONE;
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_ONE;
                2'b01:   tag_cnt <= tag_cnt - CNT_ONE;
                default: ;
            endcase
            if (rd_beat) rd_left <= tag_pop ? '0 : (beats_left - BURST_ONE);
        end
    end

    // tag FIFO storage; burstcount 0 is stored as a single beat
    always_ff @(posedge emif_usr_clk) begin
        if (tag_push) tag_mem[tag_wptr] <= {sel, sel_burst_eff};
    end

endmodule
